// File: rtl/uart_tx_arb_if.sv
// Requester write ports and UART transmitter handshake for the two-input TX arbiter.
// The master modport is the environment side; the slave modport is the arbiter side.
interface uart_tx_arb_if;
    logic       WR0;
    logic [7:0] DIN0;
    logic       FULL0;
    logic       OVF0;
    logic       WR1;
    logic [7:0] DIN1;
    logic       FULL1;
    logic       OVF1;
    logic       TX_READY;
    logic       TX_SEND;
    logic [7:0] TX_DATA;
    logic       SRC;
    logic       BUSY;

    modport master (
        output WR0, DIN0, WR1, DIN1, TX_READY,
        input  FULL0, OVF0, FULL1, OVF1, TX_SEND, TX_DATA, SRC, BUSY
    );

    modport slave (
        input  WR0, DIN0, WR1, DIN1, TX_READY,
        output FULL0, OVF0, FULL1, OVF1, TX_SEND, TX_DATA, SRC, BUSY
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Two-requester byte FIFO arbiter feeding a single UART transmitter (READY/SEND handshake),
// round-robin on ties, with a lost-handshake timeout while waiting for READY to fall.
module uart_tx_arb #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input logic          CLK,
    input logic          RST,
    uart_tx_arb_if.slave arb_io
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StIssue    = 2'd1;
    localparam logic [1:0] StWaitBusy = 2'd2;
    localparam logic [1:0] StWaitDone = 2'd3;

    localparam logic [PTR_W:0] FullCnt = (PTR_W + 1)'(DEPTH);
    localparam logic [1:0]     TmoLast = 2'd3;

    logic [7:0]            mem_q [2][DEPTH];
    logic [1:0][PTR_W-1:0] wptr_q, rptr_q;
    logic [1:0][PTR_W:0]   cnt_q, cnt_d;
    logic [1:0]            ovf_q;

    logic [1:0][7:0] din;
    logic [1:0]      wr, full, ne, wr_acc, pop;

    logic [1:0] state_q, state_d;
    logic [1:0] tmo_q, tmo_d;
    logic [7:0] data_q;
    logic       src_q;
    logic       last_q;

    logic gnt_any;
    logic gnt_idx;

    assign wr  = {arb_io.WR1, arb_io.WR0};
    assign din = {arb_io.DIN1, arb_io.DIN0};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i]   = (cnt_q[i] == FullCnt);
            ne[i]     = (cnt_q[i] != '0);
            wr_acc[i] = wr[i] & ~full[i];
        end
    end

    // Requester 0 wins the first tie because last_q resets to 1.
    assign gnt_any = (state_q == StIdle) && arb_io.TX_READY && (|ne);
    assign gnt_idx = (&ne) ? ~last_q : ne[1];
    assign pop     = gnt_any ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (wr_acc[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!wr_acc[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        case (state_q)
            StIdle: begin
                if (gnt_any) state_d = StIssue;
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                // READY never dropped: assume the SEND was lost and give up without resending.
                if (!arb_io.TX_READY) begin
                    state_d = StWaitDone;
                end else if (tmo_q == TmoLast) begin
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: begin
                if (arb_io.TX_READY) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_acc[i]) mem_q[i][wptr_q[i]] <= din[i];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= '0;
            state_q <= StIdle;
            tmo_q   <= '0;
            data_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_acc[i]) wptr_q[i] <= wptr_q[i] + 1'b1;
                if (pop[i]) rptr_q[i] <= rptr_q[i] + 1'b1;
                if (wr[i] && full[i]) ovf_q[i] <= 1'b1;
            end
            cnt_q   <= cnt_d;
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (gnt_any) begin
                data_q <= mem_q[gnt_idx][rptr_q[gnt_idx]];
                src_q  <= gnt_idx;
                last_q <= gnt_idx;
            end
        end
    end

    assign arb_io.FULL0   = full[0];
    assign arb_io.FULL1   = full[1];
    assign arb_io.OVF0    = ovf_q[0];
    assign arb_io.OVF1    = ovf_q[1];
    assign arb_io.TX_SEND = (state_q == StIssue);
    assign arb_io.TX_DATA = data_q;
    assign arb_io.SRC     = src_q;
    assign arb_io.BUSY    = (state_q != StIdle);

endmodule
